persp_divide: RTL

//  Perspective-divide stage between vertex transform and triangle setup. Accepts one

---
 rtl/persp_divide_if.sv | 28 ++
 rtl/persp_divide.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/persp_divide_if.sv
// Vertex-in / projected-vertex-out handshake bundle for the perspective-divide stage.
// Both sides use valid/ready; all data words are signed fixed point.
interface persp_divide_if;
    logic               vtx_valid_i;
    logic               vtx_ready_o;
    logic signed [31:0] x_i;
    logic signed [31:0] y_i;
    logic signed [31:0] z_i;
    logic signed [31:0] w_i;

    logic               out_valid_o;
    logic               out_ready_i;
    logic signed [31:0] x_o;
    logic signed [31:0] y_o;
    logic signed [31:0] z_o;
    logic signed [31:0] inv_w_o;
    logic               behind_o;

    modport slave (
        input  vtx_valid_i, x_i, y_i, z_i, w_i, out_ready_i,
        output vtx_ready_o, out_valid_o, x_o, y_o, z_o, inv_w_o, behind_o
    );

    modport master (
        output vtx_valid_i, x_i, y_i, z_i, w_i, out_ready_i,
        input  vtx_ready_o, out_valid_o, x_o, y_o, z_o, inv_w_o, behind_o
    );
endinterface

// File: rtl/persp_divide.sv
// Perspective divide: projects one clip-space vertex per cycle to (x/w, y/w, z/w, 1/w)
// using an external combinational reciprocal unit fed with |w|.
module persp_divide #(
    parameter int FRAC_BITS = 16,
    parameter int ROUND     = 1
) (
    input  logic                  clk,
    input  logic                  reset_ni,
    persp_divide_if.slave         vtx,
    output logic [31:0]           recip_x_o,
    input  logic [31:0]           recip_z_i
);

    localparam int DATA_W = 32;
    localparam logic signed [2*DATA_W-1:0] RND_C =
        (ROUND != 0) ? (64'sd1 <<< (FRAC_BITS - 1)) : 64'sd0;

    // |w| with the single unrepresentable magnitude (most-negative w) clamped.
    function automatic logic [DATA_W-1:0] abs_sat(input logic signed [DATA_W-1:0] w);
        logic signed [DATA_W-1:0] neg_w;
        if (w == {1'b1, {(DATA_W-1){1'b0}}})
            return {1'b0, {(DATA_W-1){1'b1}}};
        neg_w = -w;
        return w[DATA_W-1] ? neg_w : w;
    endfunction

    // Fixed-point multiply; result wraps to DATA_W bits with no saturation.
    function automatic logic signed [DATA_W-1:0] scale_round(
        input logic signed [DATA_W-1:0] a,
        input logic signed [DATA_W-1:0] inv
    );
        logic signed [2*DATA_W-1:0] ea;
        logic signed [2*DATA_W-1:0] eb;
        logic signed [2*DATA_W-1:0] p;
        ea = a;
        eb = inv;
        p  = (ea * eb) + RND_C;
        p  = p >>> FRAC_BITS;
        return p[DATA_W-1:0];
    endfunction

    logic                     w_adv;
    logic signed [DATA_W-1:0] w_recip;
    logic signed [DATA_W-1:0] w_inv;

    logic                     r_vld_p0;
    logic signed [DATA_W-1:0] r_x_p0;
    logic signed [DATA_W-1:0] r_y_p0;
    logic signed [DATA_W-1:0] r_z_p0;
    logic                     r_wneg_p0;
    logic                     r_behind_p0;
    logic        [DATA_W-1:0] r_absw_p0;

    logic                     r_vld_p1;
    logic signed [DATA_W-1:0] r_x_p1;
    logic signed [DATA_W-1:0] r_y_p1;
    logic signed [DATA_W-1:0] r_z_p1;
    logic                     r_behind_p1;
    logic signed [DATA_W-1:0] r_inv_p1;

    logic                     r_vld_p2;
    logic signed [DATA_W-1:0] r_x_p2;
    logic signed [DATA_W-1:0] r_y_p2;
    logic signed [DATA_W-1:0] r_z_p2;
    logic                     r_behind_p2;
    logic signed [DATA_W-1:0] r_inv_p2;

    // One global enable: the whole pipe moves together or freezes together.
    assign w_adv           = !r_vld_p2 || vtx.out_ready_i;
    assign vtx.vtx_ready_o = w_adv;

    assign recip_x_o = r_absw_p0;
    assign w_recip   = recip_z_i;
    assign w_inv     = r_wneg_p0 ? -w_recip : w_recip;

    // Stage 0: capture vertex, form |w| for the reciprocal unit
    always_ff @(posedge clk or negedge reset_ni) begin
        if (!reset_ni) begin
            r_vld_p0    <= 1'b0;
            r_x_p0      <= '0;
            r_y_p0      <= '0;
            r_z_p0      <= '0;
            r_wneg_p0   <= 1'b0;
            r_behind_p0 <= 1'b0;
            r_absw_p0   <= '0;
        end else if (w_adv) begin
            r_vld_p0 <= vtx.vtx_valid_i;
            if (vtx.vtx_valid_i) begin
                r_x_p0      <= vtx.x_i;
                r_y_p0      <= vtx.y_i;
                r_z_p0      <= vtx.z_i;
                r_wneg_p0   <= vtx.w_i[DATA_W-1];
                r_behind_p0 <= (vtx.w_i <= 0);
                r_absw_p0   <= abs_sat(vtx.w_i);
            end else begin
                r_absw_p0   <= '0;
            end
        end
    end

    // Stage 1: reapply the sign of w to the reciprocal
    always_ff @(posedge clk or negedge reset_ni) begin
        if (!reset_ni) begin
            r_vld_p1    <= 1'b0;
            r_x_p1      <= '0;
            r_y_p1      <= '0;
            r_z_p1      <= '0;
            r_behind_p1 <= 1'b0;
            r_inv_p1    <= '0;
        end else if (w_adv) begin
            r_vld_p1    <= r_vld_p0;
            r_x_p1      <= r_x_p0;
            r_y_p1      <= r_y_p0;
            r_z_p1      <= r_z_p0;
            r_behind_p1 <= r_behind_p0;
            r_inv_p1    <= w_inv;
        end
    end

    // Stage 2: scale x, y, z by 1/w; these registers drive the outputs directly
    always_ff @(posedge clk or negedge reset_ni) begin
        if (!reset_ni) begin
            r_vld_p2    <= 1'b0;
            r_x_p2      <= '0;
            r_y_p2      <= '0;
            r_z_p2      <= '0;
            r_behind_p2 <= 1'b0;
            r_inv_p2    <= '0;
        end else if (w_adv) begin
            r_vld_p2    <= r_vld_p1;
            r_x_p2      <= scale_round(r_x_p1, r_inv_p1);
            r_y_p2      <= scale_round(r_y_p1, r_inv_p1);
            r_z_p2      <= scale_round(r_z_p1, r_inv_p1);
            r_behind_p2 <= r_behind_p1;
            r_inv_p2    <= r_inv_p1;
        end
    end

    assign vtx.out_valid_o = r_vld_p2;
    assign vtx.x_o         = r_x_p2;
    assign vtx.y_o         = r_y_p2;
    assign vtx.z_o         = r_z_p2;
    assign vtx.inv_w_o     = r_inv_p2;
    assign vtx.behind_o    = r_behind_p2;

endmodule
